// File: rtl/forwarding_scoreboard_pkg.sv
// forwarding_scoreboard_pkg: shared register names, forward-select types and helpers
package forwarding_scoreboard_pkg;
  typedef enum logic [4:0] {
    X0, X1, X2, X3, X4, X5, X6, X7, X8, X9, X10, X11, X12, X13, X14, X15,
    X16, X17, X18, X19, X20, X21, X22, X23, X24, X25, X26, X27, X28, X29, X30, X31
  } register_e;
  typedef enum logic [1:0] {FWD_RF = 2'd0, FWD_XM = 2'd1, FWD_MW = 2'd2} forward_source_e;
  function automatic int sel_width(input int stages);
    return $clog2(stages + 1);
  endfunction
  localparam int DEFAULT_FWD_STAGES = 2;
  localparam int DEFAULT_SEL_W = sel_width(DEFAULT_FWD_STAGES);
  typedef logic [DEFAULT_SEL_W-1:0] fwd_sel_t;
endpackage

// File: rtl/forwarding_port_select.sv
// forwarding_port_select: youngest-first stage match for one operand plus load-use detect
//   i_rs/i_used        operand source register and read enable
//   i_stage_*          per-stage destination valid/address/ready, index 1 = youngest
//   o_sel              0 = register file, k = forward from stage k
//   o_load_use         winning stage has no result yet
module forwarding_port_select
  import forwarding_scoreboard_pkg::*;
#(
  parameter int NUM_FWD_STAGES = 2,
  parameter int SEL_W = sel_width(NUM_FWD_STAGES)
) (
  input  register_e                 i_rs,
  input  logic                      i_used,
  input  logic [NUM_FWD_STAGES:1]   i_stage_valid,
  input  register_e                 i_stage_addr [1:NUM_FWD_STAGES],
  input  logic [NUM_FWD_STAGES:1]   i_stage_ready,
  output logic [SEL_W-1:0]          o_sel,
  output logic                      o_load_use
);
  logic w_ready;
  // Walk oldest to youngest so the youngest match is written last and wins.
  always_comb begin
    o_sel = '0;
    w_ready = 1'b1;
    for (int k = NUM_FWD_STAGES; k >= 1; k--)
      if (i_used && i_stage_valid[k] && i_stage_addr[k] != X0 && i_stage_addr[k] == i_rs) begin
        o_sel = SEL_W'(k);
        w_ready = i_stage_ready[k];
      end
  end
  assign o_load_use = !w_ready;
endmodule

// File: rtl/forwarding_scoreboard.sv
// forwarding_scoreboard: operand forward select, load-use stall and multi-cycle latency scoreboard
//   dx_*               execute-stage operands, destination and multi-cycle issue info
//   stage_rd_*         downstream write-back stages, index 1 = youngest
//   fwd_sel_o          per-operand forward select; stall_o holds fetch/decode/execute
//   pending_o/busy_o   registers awaiting a multi-cycle result
module forwarding_scoreboard
  import forwarding_scoreboard_pkg::*;
#(
  parameter int NUM_READ_PORTS = 2,
  parameter int NUM_FWD_STAGES = 2,
  parameter int MAX_LATENCY = 8,
  localparam int LAT_W = $clog2(MAX_LATENCY + 1),
  localparam int SEL_W = sel_width(NUM_FWD_STAGES)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  register_e                            dx_rs_address_i [NUM_READ_PORTS],
  input  logic [NUM_READ_PORTS-1:0]            dx_rs_used_i,
  input  logic                                 dx_rd_valid_i,
  input  register_e                            dx_rd_address_i,
  input  logic                                 dx_multicycle_i,
  input  logic [LAT_W-1:0]                     dx_latency_i,
  input  logic                                 flush_i,
  input  logic [NUM_FWD_STAGES:1]              stage_rd_valid_i,
  input  register_e                            stage_rd_address_i [1:NUM_FWD_STAGES],
  input  logic [NUM_FWD_STAGES:1]              stage_rd_ready_i,
  output logic [NUM_READ_PORTS-1:0][SEL_W-1:0] fwd_sel_o,
  output logic                                 stall_o,
  output logic [31:0]                          pending_o,
  output logic                                 busy_o
);
  logic [LAT_W-1:0]          r_cnt [31:1];
  logic [NUM_READ_PORTS-1:0] w_load_use;
  logic [31:0]               w_pending;
  logic                      w_raw;
  logic                      w_waw;
  logic                      w_issue;
  logic [LAT_W-1:0]          w_lat;
  genvar p;
  generate
    for (p = 0; p < NUM_READ_PORTS; p++) begin : g_port
      forwarding_port_select #(.NUM_FWD_STAGES(NUM_FWD_STAGES), .SEL_W(SEL_W)) u_sel (
        .i_rs          (dx_rs_address_i[p]),
        .i_used        (dx_rs_used_i[p]),
        .i_stage_valid (stage_rd_valid_i),
        .i_stage_addr  (stage_rd_address_i),
        .i_stage_ready (stage_rd_ready_i),
        .o_sel         (fwd_sel_o[p]),
        .o_load_use    (w_load_use[p])
      );
    end
  endgenerate
  always_comb begin
    w_pending = '0;
    for (int r = 1; r < 32; r++) w_pending[r] = r_cnt[r] != '0;
  end
  always_comb begin
    w_raw = 1'b0;
    for (int i = 0; i < NUM_READ_PORTS; i++) w_raw = w_raw | (dx_rs_used_i[i] && w_pending[dx_rs_address_i[i]]);
  end
  assign w_waw = dx_rd_valid_i && dx_rd_address_i != X0 && w_pending[dx_rd_address_i];
  assign stall_o = |w_load_use || w_raw || w_waw;
  assign w_issue = dx_multicycle_i && dx_rd_valid_i && dx_rd_address_i != X0 && !stall_o && !flush_i;
  // A zero latency still occupies one cycle so the write-through cycle is covered.
  assign w_lat = (dx_latency_i == '0) ? LAT_W'(1)
               : (dx_latency_i > LAT_W'(MAX_LATENCY)) ? LAT_W'(MAX_LATENCY) : dx_latency_i;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni)
      for (int r = 1; r < 32; r++) r_cnt[r] <= '0;
    else
      for (int r = 1; r < 32; r++)
        if (w_issue && dx_rd_address_i == register_e'(r)) r_cnt[r] <= w_lat;
        else if (r_cnt[r] != '0) r_cnt[r] <= r_cnt[r] - LAT_W'(1);
  assign pending_o = w_pending;
  assign busy_o = |w_pending;
endmodule

// File: doc/forwarding_scoreboard.md
Name: forwarding_scoreboard

Overview:
- Parametrised successor to the two-port, two-stage forwarding selector.
- Serves NUM_READ_PORTS execute-stage operands against NUM_FWD_STAGES downstream write-back stages, youngest first.
- Adds load-use stall detection through per-stage "result ready" flags.
- Adds a per-register latency scoreboard for multi-cycle ops (mul/div) that stalls RAW/WAW hazards until the op retires.
- Sits beside the decode/execute pipeline register; drives the operand muxes and the pipeline stall.

Parameters:
- NUM_READ_PORTS, 2, number of execute-stage source operands checked.
- NUM_FWD_STAGES, 2, number of forwardable downstream stages; index 1 = youngest (X/M).
- MAX_LATENCY, 8, largest multi-cycle op latency accepted; LAT_W = $clog2(MAX_LATENCY+1).
- SEL_W, $clog2(NUM_FWD_STAGES+1), derived; width of each forward-select field.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset; asynchronous assert, active low.
- dx_rs_address_i  input  NUM_READ_PORTS x register_e  source register per operand.
- dx_rs_used_i  input  NUM_READ_PORTS  operand is actually read.
- dx_rd_valid_i  input  1  execute instruction writes rd.
- dx_rd_address_i  input  register_e  execute destination.
- dx_multicycle_i  input  1  execute instruction is a multi-cycle op.
- dx_latency_i  input  LAT_W  cycles until its result is in the register file.
- flush_i  input  1  execute instruction is squashed this cycle.
- stage_rd_valid_i  input  NUM_FWD_STAGES  stage k writes rd.
- stage_rd_address_i  input  NUM_FWD_STAGES x register_e  stage k destination.
- stage_rd_ready_i  input  NUM_FWD_STAGES  stage k result is available for forwarding (0 for a load still in MEM).
- fwd_sel_o  output  NUM_READ_PORTS x SEL_W  0 = register file, k = forward from stage k.
- stall_o  output  1  hold fetch/decode/execute this cycle.
- pending_o  output  32  scoreboard bitmap; bit 0 is always 0.
- busy_o  output  1  any scoreboard entry pending.

Behaviour:
- Forward select (combinational, per port p):
  - Lowest k wins where stage_rd_valid_i[k], stage_rd_address_i[k] != 0, stage_rd_address_i[k] == dx_rs_address_i[p], and dx_rs_used_i[p].
  - No match or x0 gives 0.
- Load-use: if the winning stage k has stage_rd_ready_i[k] = 0, assert stall_o. fwd_sel_o still reports k. Older stages are not consulted.
- Scoreboard state: per register r in 1..31, a counter cnt[r] of LAT_W bits; pending[r] = (cnt[r] != 0).
- RAW: stall_o if any used operand reads a pending register.
- WAW: stall_o if dx_rd_valid_i and dx_rd_address_i is pending and != 0.
- Issue condition: dx_multicycle_i && dx_rd_valid_i && dx_rd_address_i != 0 && !stall_o && !flush_i.
  - On issue, cnt[rd] <= max(dx_latency_i, 1).
  - Latency values above MAX_LATENCY saturate to MAX_LATENCY.
- Countdown: every cycle each nonzero cnt not being issued decrements by 1.
  - Issue at edge T with latency L gives pending visible for cycles T+1..T+L; clear from cycle T+L+1.
  - The register file is write-through on the final cycle, so no forwarding from the scoreboard.
- Simultaneous events:
  - Issue to r while cnt[r] == 1: impossible, because WAW stalls first.
  - Issue to r in the same cycle another entry expires: independent.
  - Flush with stall: no issue, counters still decrement.
- pending_o[0] and cnt[0] are hard-wired to 0.
- busy_o = |pending_o.
- Reset (async, active low) clears all counters mid-operation. With zero inputs, the outputs are fwd_sel_o = 0, stall_o = 0, pending_o = 0, busy_o = 0.
- No registered outputs: forward select and stall have 0-cycle latency; scoreboard update has 1-cycle latency.

Decomposition:
- Shared package (extend the forwarding header): SEL_W helper function, fwd_sel_t, existing register_e; keep forward_source_e for the legacy block.
- One natural sub-module: forwarding_port_select. This is the per-operand priority match and ready check, instantiated NUM_READ_PORTS times via generate.
- The counter array stays in the top module.

Test Plan:
- Stage1 rd = x5 valid ready; stage2 rd = x5 valid ready; rs1 = x5 -> fwd_sel_o[0] = 1, stall_o = 0. Drop stage1 -> fwd_sel_o[0] = 2.
- rs2 = x0, all stages rd = x0 valid -> fwd_sel_o[1] = 0, stall_o = 0.
- Load-use: stage1 rd = x7 ready = 0, rs1 = x7 used -> stall_o = 1, fwd_sel_o[0] = 1. Same with dx_rs_used_i[0] = 0 -> stall_o = 0.
- Issue multicycle rd = x10 latency 3 at cycle 0 -> pending_o[10] = 1 in cycles 1-3, 0 in cycle 4. rs1 = x10 stalls exactly cycles 1-3. A second instruction writing x10 (WAW) stalls over the same window.
- Latency 0 -> pending for 1 cycle. Latency MAX_LATENCY+5 (if representable) -> pending MAX_LATENCY cycles. flush_i with a multicycle issue -> pending_o stays 0.
- Issue x3 latency 8, assert rst_ni = 0 at cycle 4 (async, mid-clock) -> pending_o = 0, busy_o = 0 immediately. After release, rs = x3 does not stall.
